// File: rtl/kb_pkg.sv
// Shared keypad constants, debounce state encoding and seven-segment decode
// used by the keypad entry/display path.
package kb_pkg;

    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    // Segments are {A,B,C,D,E,F,G}, active-high; anything that is not 0-9 is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kb_debounce.sv
// Debounces the scanner's key code / key-present flag into one strobe per press.
// AccStb/AccCode expose the accept decision combinationally so the consumer can
// update on the same edge that raises the registered KeyStb.
module kb_debounce
    import kb_pkg::*;
#(
    parameter int DEB_CNT = 16
) (
    input  logic       Clk10M,
    input  logic       Clr_n,
    input  logic [3:0] Key,
    input  logic       KeyVld,
    output logic       KeyStb,
    output logic [3:0] KeyCode,
    output logic       AccStb,
    output logic [3:0] AccCode
);

    localparam int             CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    kc_q, kc_d;
    logic          stb_q, stb_d;
    logic [3:0]    code_q, code_d;
    logic          acc_s;

    // Next-state and counter logic; the accept fires on the DEB_CNT-th matching sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kc_d    = kc_q;
        acc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (KeyVld) begin
                    kc_d    = Key;
                    cnt_d   = CNT_ONE;
                    state_d = PRESS_WAIT;
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!KeyVld) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (Key != kc_q) begin
                    kc_d  = Key;
                    cnt_d = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    acc_s   = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!KeyVld) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE_WAIT;
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (KeyVld) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        stb_d  = acc_s;
        code_d = acc_s ? kc_q : code_q;
    end

    // FSM, counter and registered strobe/code.
    always_ff @(posedge Clk10M or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kc_q    <= 4'd0;
            stb_q   <= 1'b0;
            code_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kc_q    <= kc_d;
            stb_q   <= stb_d;
            code_q  <= code_d;
        end
    end

    assign KeyStb  = stb_q;
    assign KeyCode = code_q;
    assign AccStb  = acc_s;
    assign AccCode = kc_q;

endmodule

// File: rtl/kb_entry_display.sv
// Keypad entry: debounced presses feed a 4-digit BCD buffer that is committed on '#'
// and shown on a time-multiplexed, active-low-select seven-segment display.
module kb_entry_display
    import kb_pkg::*;
#(
    parameter int DEB_CNT = 16,
    parameter int DIV     = 1024
) (
    input  logic        Clk10M,
    input  logic        Clr_n,
    input  logic [3:0]  Key,
    input  logic        KeyVld,
    output logic        KeyStb,
    output logic [3:0]  KeyCode,
    output logic [15:0] Value,
    output logic        Done,
    output logic [6:0]  Seg,
    output logic [3:0]  Dsel
);

    localparam int            DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic            acc_s;
    logic [3:0]      acc_code_s;
    logic [3:0][3:0] dig_q, dig_d;
    logic [15:0]     value_q, value_d;
    logic            done_q, done_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dsel_q, dsel_d;

    function automatic logic [3:0] blank_to_zero(input logic [3:0] d);
        return (d == DIG_BLANK) ? 4'd0 : d;
    endfunction

    kb_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .Clk10M  (Clk10M),
        .Clr_n   (Clr_n),
        .Key     (Key),
        .KeyVld  (KeyVld),
        .KeyStb  (KeyStb),
        .KeyCode (KeyCode),
        .AccStb  (acc_s),
        .AccCode (acc_code_s)
    );

    // Buffer shift / clear / commit on an accepted press; codes 12-15 leave it alone.
    always_comb begin
        dig_d   = dig_q;
        value_d = value_q;
        done_d  = 1'b0;
        if (acc_s) begin
            if (acc_code_s <= 4'd9) begin
                dig_d = {dig_q[2:0], acc_code_s};
            end else if (acc_code_s == KEY_STAR) begin
                dig_d = {4{DIG_BLANK}};
            end else if (acc_code_s == KEY_HASH) begin
                value_d = {blank_to_zero(dig_q[3]), blank_to_zero(dig_q[2]),
                           blank_to_zero(dig_q[1]), blank_to_zero(dig_q[0])};
                done_d  = 1'b1;
                dig_d   = {4{DIG_BLANK}};
            end else begin
                dig_d = dig_q;
            end
        end else begin
            dig_d = dig_q;
        end
    end

    // Scan divider and digit index; Seg uses the next buffer so updates show at once.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + DW'(1);
            idx_d = idx_q;
        end
        dsel_d = ~(4'b0001 << idx_d);
        seg_d  = seg_decode(dig_d[idx_d]);
    end

    // Buffer, committed value and display registers.
    always_ff @(posedge Clk10M or negedge Clr_n) begin
        if (!Clr_n) begin
            dig_q   <= {4{DIG_BLANK}};
            value_q <= 16'h0000;
            done_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'b0000000;
            dsel_q  <= 4'b1110;
        end else begin
            dig_q   <= dig_d;
            value_q <= value_d;
            done_q  <= done_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dsel_q  <= dsel_d;
        end
    end

    assign Value = value_q;
    assign Done  = done_q;
    assign Seg   = seg_q;
    assign Dsel  = dsel_q;

endmodule

// File: tb/tb_kb_entry_display.sv
// Self-checking bench for kb_entry_display (DEB_CNT=4, DIV=8): a strobe scoreboard
// plus a table of key presses and hand-written bounce/reset/display sequences.
module tb_kb_entry_display;

    localparam int DEB = 4;
    localparam int DV  = 8;

    logic        Clk10M;
    logic        Clr_n;
    logic [3:0]  Key;
    logic        KeyVld;
    logic        KeyStb;
    logic [3:0]  KeyCode;
    logic [15:0] Value;
    logic        Done;
    logic [6:0]  Seg;
    logic [3:0]  Dsel;

    typedef struct {
        logic [3:0]  code;
        logic        done;
        logic [15:0] value;
    } exp_t;

    typedef struct {
        logic [3:0]  key;
        logic        done;
        logic [15:0] value;
        logic        blank_chk;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[13];
    int   errors = 0;
    int   checks = 0;
    int   stb_cnt = 0;

    kb_entry_display #(.DEB_CNT(DEB), .DIV(DV)) dut (
        .Clk10M  (Clk10M),
        .Clr_n   (Clr_n),
        .Key     (Key),
        .KeyVld  (KeyVld),
        .KeyStb  (KeyStb),
        .KeyCode (KeyCode),
        .Value   (Value),
        .Done    (Done),
        .Seg     (Seg),
        .Dsel    (Dsel)
    );

    initial Clk10M = 1'b0;
    always #50 Clk10M = ~Clk10M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Scoreboard: every strobe pops the expected code / Done / Value.
    always @(negedge Clk10M) begin
        if (Clr_n) begin
            if (KeyStb) begin
                stb_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_stb", 32'(KeyStb), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_code", 32'(KeyCode), 32'(e.code));
                    chk("sb_done", 32'(Done), 32'(e.done));
                    chk("sb_value", 32'(Value), 32'(e.value));
                end
            end else if (Done) begin
                chk("done_without_stb", 32'(Done), 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] k);
        @(negedge Clk10M);
        KeyVld = v;
        Key    = k;
    endtask

    task automatic release_keys(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0);
    endtask

    // Clean press: strobe exactly on the DEB-th sample edge, one cycle wide.
    task automatic press(input logic [3:0] k, input logic dn, input logic [15:0] v);
        exp_q.push_back('{k, dn, v});
        for (int i = 0; i < DEB; i++) begin
            @(negedge Clk10M);
            if (i == DEB - 1) chk("stb_early", 32'(KeyStb), 32'd0);
            KeyVld = 1'b1;
            Key    = k;
        end
        @(negedge Clk10M);
        chk("stb_edge", 32'(KeyStb), 32'd1);
        @(negedge Clk10M);
        chk("stb_width", 32'({KeyStb, Done}), 32'd0);
        release_keys(DEB + 1);
    endtask

    // Check a full scan cycle starting at the first cycle Dsel selects digit 0.
    task automatic disp_check(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] ds[4];
        logic [3:0] prev;
        logic [3:0] ed;
        bit         found;
        ds    = '{d0, d1, d2, d3};
        prev  = Dsel;
        found = 1'b0;
        for (int n = 0; n < 4 * DV + 2 && !found; n++) begin
            @(negedge Clk10M);
            if (prev != 4'b1110 && Dsel == 4'b1110) found = 1'b1;
            else prev = Dsel;
        end
        chk("disp_align", 32'(found), 32'd1);
        if (found) begin
            for (int d = 0; d < 4; d++) begin
                ed    = 4'b1111;
                ed[d] = 1'b0;
                for (int c = 0; c < DV; c++) begin
                    chk("disp_dsel", 32'(Dsel), 32'(ed));
                    chk("disp_seg", 32'(Seg), 32'(seg_of(ds[d])));
                    @(negedge Clk10M);
                end
            end
        end
    endtask

    initial begin
        int base;
        tbl[0]  = '{4'd1,  1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{4'd2,  1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{4'd3,  1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{4'd4,  1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{4'd5,  1'b0, 16'h0000, 1'b0};
        tbl[5]  = '{4'd11, 1'b1, 16'h2345, 1'b1};
        tbl[6]  = '{4'd9,  1'b0, 16'h2345, 1'b0};
        tbl[7]  = '{4'd10, 1'b0, 16'h2345, 1'b1};
        tbl[8]  = '{4'd11, 1'b1, 16'h0000, 1'b1};
        tbl[9]  = '{4'd1,  1'b0, 16'h0000, 1'b0};
        tbl[10] = '{4'd2,  1'b0, 16'h0000, 1'b0};
        tbl[11] = '{4'd3,  1'b0, 16'h0000, 1'b0};
        tbl[12] = '{4'd4,  1'b0, 16'h0000, 1'b0};

        // Reset held with KeyVld toggling.
        Clr_n  = 1'b0;
        KeyVld = 1'b0;
        Key    = 4'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk10M);
            chk("reset_state", 32'({KeyStb, Done, Value, Dsel, Seg}), 32'({1'b0, 1'b0, 16'h0000, 4'b1110, 7'b0}));
            KeyVld = ~KeyVld;
        end
        @(negedge Clk10M);
        Clr_n  = 1'b1;
        KeyVld = 1'b0;

        // Short press after release: 3 samples must not strobe.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd5);
        release_keys(DEB + 2);
        chk("short_press_no_stb", 32'(stb_cnt), 32'd0);

        // Clean press of 7 held 20 cycles.
        exp_q.push_back('{4'd7, 1'b0, 16'h0000});
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk10M);
            if (i > 0) chk("hold7_stb", 32'(KeyStb), 32'(i == DEB));
            KeyVld = 1'b1;
            Key    = 4'd7;
        end
        release_keys(DEB + 1);
        chk("hold7_count", 32'(stb_cnt), 32'd1);
        chk("hold7_code", 32'(KeyCode), 32'd7);
        disp_check(4'd7, 4'hF, 4'hF, 4'hF);

        // Bounce on press, then bounce on release.
        base = stb_cnt;
        exp_q.push_back('{4'd3, 1'b0, 16'h0000});
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk10M);
            if (i > 0) chk("bounce_early", 32'(KeyStb), 32'd0);
            KeyVld = (i != 2);
            Key    = 4'd3;
        end
        @(negedge Clk10M);
        chk("bounce_stb", 32'(KeyStb), 32'd1);
        KeyVld = 1'b1;
        drive(1'b1, 4'd3);
        drive(1'b0, 4'd3);
        drive(1'b0, 4'd3);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd3);
        release_keys(DEB + 2);
        chk("bounce_count", 32'(stb_cnt - base), 32'd1);

        // Key change inside the window restarts it.
        exp_q.push_back('{4'd2, 1'b0, 16'h0000});
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd1);
        for (int i = 0; i < DEB; i++) begin
            @(negedge Clk10M);
            chk("change_early", 32'(KeyStb), 32'd0);
            KeyVld = 1'b1;
            Key    = 4'd2;
        end
        @(negedge Clk10M);
        chk("change_stb", 32'(KeyStb), 32'd1);
        release_keys(DEB + 1);

        // Entry table.
        for (int i = 0; i < 13; i++) begin
            press(tbl[i].key, tbl[i].done, tbl[i].value);
            if (tbl[i].blank_chk) disp_check(4'hF, 4'hF, 4'hF, 4'hF);
        end

        // Display scan of 1,2,3,4; an invalid code leaves it unchanged.
        disp_check(4'd4, 4'd3, 4'd2, 4'd1);
        press(4'd13, 1'b0, 16'h0000);
        disp_check(4'd4, 4'd3, 4'd2, 4'd1);
        press(4'd11, 1'b1, 16'h1234);
        chk("value_1234", 32'(Value), 32'h1234);

        // Asynchronous reset mid-press, then a full-window press afterwards.
        drive(1'b1, 4'd8);
        drive(1'b1, 4'd8);
        #20;
        Clr_n = 1'b0;
        #1;
        chk("async_reset", 32'({KeyStb, Done, Value, Dsel, Seg}), 32'({1'b0, 1'b0, 16'h0000, 4'b1110, 7'b0}));
        @(negedge Clk10M);
        KeyVld = 1'b0;
        Clr_n  = 1'b1;
        press(4'd6, 1'b0, 16'h0000);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
